resource_dispenser: RTL and testbench

Consumer-side controller for the suit resource stores (energy 8-bit, spider tracers 6-bit, fluid 4-bit). It accepts action requests over a valid/ready handshake and checks the cost against the current store levels. If the request is affordable, it writes the decremented level back through the stores' load/enable ports; either way it returns a granted/denied response. It sits between the action decoder upstream and the three storage registers downstream, and is their only writer after the initial load.

---
 rtl/resource_pkg.sv | 27 ++
 rtl/resource_sub_check.sv | 15 +
 rtl/resource_dispenser.sv | 221 ++++++++++++++++++++++
 tb/tb_resource_dispenser.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/resource_pkg.sv
// Shared types and widths for the suit resource stores and the dispenser FSM.
package resource_pkg;

    localparam int ENERGY_W = 8;
    localparam int TRACER_W = 6;
    localparam int FLUID_W  = 4;

    localparam logic [ENERGY_W-1:0] ENERGY_FULL = 8'd255;
    localparam logic [TRACER_W-1:0] TRACER_FULL = 6'd63;
    localparam logic [FLUID_W-1:0]  FLUID_FULL  = 4'd15;

    typedef enum logic [1:0] {
        KIND_REPULSOR = 2'd0,
        KIND_WEB      = 2'd1,
        KIND_HEAL     = 2'd2,
        KIND_COMBO    = 2'd3
    } act_kind_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        COMMIT = 3'd2,
        DENY   = 3'd3,
        RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/resource_sub_check.sv
// Unsigned level-minus-cost for one store of width W; combinational, no backpressure.
// A cost wider than the store always compares as short, so range errors fold into the borrow.
module resource_sub_check #(
    parameter int W = 8
) (
    input  logic [W-1:0] level_i,
    input  logic [7:0]   cost_i,
    output logic [W-1:0] diff_o,
    output logic         short_o
);

    assign short_o = cost_i > 8'(level_i);
    assign diff_o  = level_i - cost_i[W-1:0];

endmodule

// File: rtl/resource_dispenser.sv
// Checks action cost against the resource stores and writes back the decremented level.
// Latency: accept T0, CHECK T1, write pulse T2, response from T3; act_ready low until rsp handshake.
// Optional energy recharge under RESOURCE_RECHARGE_EN; recharge writes steal act_ready for one IDLE cycle.
module resource_dispenser
    import resource_pkg::*;
#(
    parameter int RECHARGE_PERIOD = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                act_valid,
    output logic                act_ready,
    input  logic [1:0]          act_kind,
    input  logic [7:0]          act_cost,
    input  logic [ENERGY_W-1:0] energy_q,
    input  logic [TRACER_W-1:0] tracer_q,
    input  logic [FLUID_W-1:0]  fluid_q,
    output logic [ENERGY_W-1:0] energy_d,
    output logic                energy_we,
    output logic [TRACER_W-1:0] tracer_d,
    output logic                tracer_we,
    output logic [FLUID_W-1:0]  fluid_d,
    output logic                fluid_we,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_granted,
    output logic [7:0]          rsp_remaining
);

    state_e              state_q, state_d;
    act_kind_e           kind_q, kind_d;
    logic [7:0]          cost_q, cost_d;
    logic                act_ready_q, act_ready_d;
    logic [ENERGY_W-1:0] energy_dat_q, energy_dat_d;
    logic [TRACER_W-1:0] tracer_dat_q, tracer_dat_d;
    logic [FLUID_W-1:0]  fluid_dat_q, fluid_dat_d;
    logic                energy_we_q, energy_we_d;
    logic                tracer_we_q, tracer_we_d;
    logic                fluid_we_q, fluid_we_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                granted_q, granted_d;
    logic [7:0]          remaining_q, remaining_d;

    logic [ENERGY_W-1:0] e_diff;
    logic [TRACER_W-1:0] t_diff;
    logic [FLUID_W-1:0]  f_diff;
    logic                e_short, t_short, f_short;
    logic [7:0]          f_cost;
    logic                use_energy, use_tracer, use_fluid, deny;
    logic [7:0]          remaining;

    // Combo always burns exactly one unit of fluid on top of the energy cost.
    assign f_cost = (kind_q == KIND_COMBO) ? 8'd1 : cost_q;

    resource_sub_check #(.W(ENERGY_W)) u_energy_chk (
        .level_i(energy_q), .cost_i(cost_q), .diff_o(e_diff), .short_o(e_short)
    );
    resource_sub_check #(.W(TRACER_W)) u_tracer_chk (
        .level_i(tracer_q), .cost_i(cost_q), .diff_o(t_diff), .short_o(t_short)
    );
    resource_sub_check #(.W(FLUID_W)) u_fluid_chk (
        .level_i(fluid_q), .cost_i(f_cost), .diff_o(f_diff), .short_o(f_short)
    );

    always_comb begin
        use_energy = 1'b0;
        use_tracer = 1'b0;
        use_fluid  = 1'b0;
        deny       = 1'b0;
        remaining  = '0;
        case (kind_q)
            KIND_REPULSOR: begin
                use_energy = 1'b1;
                deny       = e_short;
                remaining  = e_short ? energy_q : e_diff;
            end
            KIND_WEB: begin
                use_tracer = 1'b1;
                deny       = t_short;
                remaining  = {{(8-TRACER_W){1'b0}}, (t_short ? tracer_q : t_diff)};
            end
            KIND_HEAL: begin
                use_fluid = 1'b1;
                deny      = f_short;
                remaining = {{(8-FLUID_W){1'b0}}, (f_short ? fluid_q : f_diff)};
            end
            default: begin
                use_energy = 1'b1;
                use_fluid  = 1'b1;
                deny       = e_short | f_short;
                remaining  = deny ? energy_q : e_diff;
            end
        endcase
    end

`ifdef RESOURCE_RECHARGE_EN
    logic [15:0] rch_cnt_q;
    logic        rch_pend_q;
    logic        rch_tick;
    logic        rch_clr;

    assign rch_tick = (rch_cnt_q == 16'(RECHARGE_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rch_cnt_q  <= '0;
            rch_pend_q <= 1'b0;
        end else begin
            rch_cnt_q  <= rch_tick ? '0 : rch_cnt_q + 16'd1;
            rch_pend_q <= (rch_pend_q & ~rch_clr) | rch_tick;
        end
    end
`else
    logic unused_recharge_cfg;
    assign unused_recharge_cfg = (RECHARGE_PERIOD > 0);
`endif

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        cost_d       = cost_q;
        energy_we_d  = 1'b0;
        tracer_we_d  = 1'b0;
        fluid_we_d   = 1'b0;
        energy_dat_d = '0;
        tracer_dat_d = '0;
        fluid_dat_d  = '0;
        granted_d    = granted_q;
        remaining_d  = remaining_q;
`ifdef RESOURCE_RECHARGE_EN
        rch_clr      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (act_valid && act_ready_q) begin
                    state_d = CHECK;
                    kind_d  = act_kind_e'(act_kind);
                    cost_d  = act_cost;
                end
            end
            CHECK: begin
                state_d     = deny ? DENY : COMMIT;
                granted_d   = ~deny;
                remaining_d = remaining;
                if (!deny) begin
                    energy_we_d = use_energy && (cost_q != 8'd0);
                    tracer_we_d = use_tracer && (cost_q != 8'd0);
                    fluid_we_d  = use_fluid  && (f_cost != 8'd0);
                end
                energy_dat_d = energy_we_d ? e_diff : '0;
                tracer_dat_d = tracer_we_d ? t_diff : '0;
                fluid_dat_d  = fluid_we_d  ? f_diff : '0;
            end
            COMMIT, DENY: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    granted_d   = 1'b0;
                    remaining_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef RESOURCE_RECHARGE_EN
        // Skip while a write is still landing so energy_q is never stale.
        if (state_d == IDLE && rch_pend_q && !energy_we_q) begin
            rch_clr = 1'b1;
            if (energy_q != ENERGY_FULL) begin
                energy_we_d  = 1'b1;
                energy_dat_d = energy_q + 8'd1;
            end
        end
`endif
        rsp_valid_d = (state_d == RESP);
        act_ready_d = (state_d == IDLE) && !energy_we_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            kind_q       <= KIND_REPULSOR;
            cost_q       <= '0;
            act_ready_q  <= 1'b0;
            energy_we_q  <= 1'b0;
            tracer_we_q  <= 1'b0;
            fluid_we_q   <= 1'b0;
            energy_dat_q <= '0;
            tracer_dat_q <= '0;
            fluid_dat_q  <= '0;
            rsp_valid_q  <= 1'b0;
            granted_q    <= 1'b0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            cost_q       <= cost_d;
            act_ready_q  <= act_ready_d;
            energy_we_q  <= energy_we_d;
            tracer_we_q  <= tracer_we_d;
            fluid_we_q   <= fluid_we_d;
            energy_dat_q <= energy_dat_d;
            tracer_dat_q <= tracer_dat_d;
            fluid_dat_q  <= fluid_dat_d;
            rsp_valid_q  <= rsp_valid_d;
            granted_q    <= granted_d;
            remaining_q  <= remaining_d;
        end
    end

    assign act_ready     = act_ready_q;
    assign energy_d      = energy_dat_q;
    assign energy_we     = energy_we_q;
    assign tracer_d      = tracer_dat_q;
    assign tracer_we     = tracer_we_q;
    assign fluid_d       = fluid_dat_q;
    assign fluid_we      = fluid_we_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_granted   = granted_q;
    assign rsp_remaining = remaining_q;

endmodule

// File: tb/tb_resource_dispenser.sv
// Scoreboard bench for resource_dispenser with a behavioural model of the three stores.
module tb_resource_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       act_valid, act_ready;
    logic [1:0] act_kind;
    logic [7:0] act_cost;
    logic [7:0] energy_d;
    logic [5:0] tracer_d;
    logic [3:0] fluid_d;
    logic       energy_we, tracer_we, fluid_we;
    logic       rsp_valid, rsp_ready, rsp_granted;
    logic [7:0] rsp_remaining;

    logic [7:0] st_e;
    logic [5:0] st_t;
    logic [3:0] st_f;
    logic       frc_en;
    logic [7:0] frc_e;
    logic [5:0] frc_t;
    logic [3:0] frc_f;

    typedef struct packed {
        logic       g;
        logic [7:0] rem;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    resource_dispenser #(.RECHARGE_PERIOD(4)) dut (
        .clk(clk), .reset(reset),
        .act_valid(act_valid), .act_ready(act_ready),
        .act_kind(act_kind), .act_cost(act_cost),
        .energy_q(st_e), .tracer_q(st_t), .fluid_q(st_f),
        .energy_d(energy_d), .energy_we(energy_we),
        .tracer_d(tracer_d), .tracer_we(tracer_we),
        .fluid_d(fluid_d), .fluid_we(fluid_we),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_granted(rsp_granted), .rsp_remaining(rsp_remaining)
    );

    // Store registers: forced preload wins, otherwise apply dispenser writes.
    always @(posedge clk) begin
        if (frc_en) begin
            st_e <= frc_e;
            st_t <= frc_t;
            st_f <= frc_f;
        end else begin
            if (energy_we) st_e <= energy_d;
            if (tracer_we) st_t <= tracer_d;
            if (fluid_we)  st_f <= fluid_d;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got response %0d/%0d with empty scoreboard",
                         rsp_granted, rsp_remaining);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_granted", rsp_granted, e.g);
                chk("rsp_remaining", rsp_remaining, e.rem);
            end
        end
    end

    task automatic do_action(
        input logic [1:0] kind, input logic [7:0] cost,
        input logic [7:0] e, input logic [5:0] t, input logic [3:0] f,
        input logic g, input logic [7:0] rem,
        input logic [2:0] we_exp, input logic [7:0] ed, input logic [5:0] td, input logic [3:0] fd,
        input int hold, input bit rst_resp
    );
        bit   got;
        rsp_t r;
        got    = 1'b0;
        frc_e  = e;
        frc_t  = t;
        frc_f  = f;
        frc_en = 1'b1;
        rsp_ready = (hold == 0) && !rst_resp;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (act_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_wait", got, 1);
        act_valid = 1'b1;
        act_kind  = kind;
        act_cost  = cost;
        @(posedge clk);
        #1;
        act_valid = 1'b0;
        frc_en    = 1'b0;
        if (!rst_resp) begin
            r.g   = g;
            r.rem = rem;
            exp_q.push_back(r);
        end
        @(negedge clk);
        chk("t1_no_we", {energy_we, tracer_we, fluid_we}, 0);
        @(negedge clk);
        chk("t2_we", {energy_we, tracer_we, fluid_we}, we_exp);
        if (we_exp[2]) chk("t2_energy_d", energy_d, ed);
        if (we_exp[1]) chk("t2_tracer_d", tracer_d, td);
        if (we_exp[0]) chk("t2_fluid_d", fluid_d, fd);
        @(negedge clk);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_no_we", {energy_we, tracer_we, fluid_we}, 0);
        if (rst_resp) begin
            reset = 1'b1;
            @(negedge clk);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_act_ready", act_ready, 0);
            reset = 1'b0;
            @(negedge clk);
            chk("rst_release_act_ready", act_ready, 1);
            rsp_ready = 1'b1;
        end else if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", rsp_valid, 1);
                chk("hold_granted", rsp_granted, g);
                chk("hold_remaining", rsp_remaining, rem);
                chk("hold_act_ready", act_ready, 0);
            end
            @(posedge clk);
            #1 rsp_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("post_rsp_valid", rsp_valid, 0);
`ifdef RESOURCE_RECHARGE_EN
            chk("rch_after_action_we", energy_we, 1);
            chk("rch_after_action_d", energy_d, 8'(rem + 8'd1));
            chk("rch_after_action_act_ready", act_ready, 0);
`else
            chk("idle_no_we", energy_we, 0);
            chk("idle_act_ready", act_ready, 1);
`endif
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n_we;
        logic [7:0] last_d;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        act_valid = 1'b0;
        act_kind  = 2'd0;
        act_cost  = 8'd0;
        frc_en    = 1'b1;
        frc_e     = 8'd0;
        frc_t     = 6'd0;
        frc_f     = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_act_ready", act_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_we", {energy_we, tracer_we, fluid_we}, 0);
        chk("reset_d", {energy_d, tracer_d, fluid_d}, 0);
        chk("reset_rsp_data", {rsp_granted, rsp_remaining}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_cycle_act_ready", act_ready, 1);

        //        kind   cost    e        t      f      g     rem     we      ed      td     fd   hold rst
        do_action(2'd0, 8'd10, 8'd255, 6'd0,  4'd0,  1'b1, 8'd245, 3'b100, 8'd245, 6'd0,  4'd0, 0, 1'b0);
        do_action(2'd1, 8'd6,  8'd0,   6'd5,  4'd0,  1'b0, 8'd5,   3'b000, 8'd0,   6'd0,  4'd0, 0, 1'b0);
        do_action(2'd1, 8'd64, 8'd0,   6'd63, 4'd0,  1'b0, 8'd63,  3'b000, 8'd0,   6'd0,  4'd0, 0, 1'b0);
        do_action(2'd3, 8'd2,  8'd3,   6'd0,  4'd0,  1'b0, 8'd3,   3'b000, 8'd0,   6'd0,  4'd0, 0, 1'b0);
        do_action(2'd3, 8'd10, 8'd10,  6'd0,  4'd1,  1'b1, 8'd0,   3'b101, 8'd0,   6'd0,  4'd0, 0, 1'b0);
        do_action(2'd2, 8'd15, 8'd0,   6'd0,  4'd15, 1'b1, 8'd0,   3'b001, 8'd0,   6'd0,  4'd0, 0, 1'b0);
        do_action(2'd0, 8'd0,  8'd50,  6'd0,  4'd0,  1'b1, 8'd50,  3'b000, 8'd0,   6'd0,  4'd0, 0, 1'b0);
        do_action(2'd2, 8'd16, 8'd0,   6'd0,  4'd7,  1'b0, 8'd7,   3'b000, 8'd0,   6'd0,  4'd0, 0, 1'b0);
        do_action(2'd1, 8'd13, 8'd0,   6'd40, 4'd0,  1'b1, 8'd27,  3'b010, 8'd0,   6'd27, 4'd0, 0, 1'b0);
        do_action(2'd3, 8'd0,  8'd0,   6'd0,  4'd5,  1'b1, 8'd0,   3'b001, 8'd0,   6'd0,  4'd4, 0, 1'b0);
        do_action(2'd0, 8'd1,  8'd100, 6'd0,  4'd0,  1'b1, 8'd99,  3'b100, 8'd99,  6'd0,  4'd0, 5, 1'b0);
        do_action(2'd1, 8'd3,  8'd0,   6'd10, 4'd0,  1'b1, 8'd7,   3'b010, 8'd0,   6'd7,  4'd0, 0, 1'b1);

        // Idle near-full energy: recharge builds top up once and stop; others never write.
        frc_e  = 8'd254;
        frc_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 frc_en = 1'b0;
        n_we   = 0;
        last_d = 8'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (energy_we) begin
                n_we++;
                last_d = energy_d;
            end
        end
`ifdef RESOURCE_RECHARGE_EN
        chk("idle_recharge_count", n_we, 1);
        chk("idle_recharge_value", last_d, 255);
        chk("idle_recharge_store", st_e, 255);
`else
        chk("idle_write_count", n_we, 0);
        chk("idle_energy_kept", st_e, 254);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
